dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_pkg.sv | 14 +
 rtl/dmem_responder_word_ram.sv | 33 +++
 rtl/dmem_responder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and widths for the data-memory responder and its word RAM.
package dmem_responder_pkg;

    localparam int WORD_W = 32;
    localparam int STRB_W = WORD_W / 8;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_responder_word_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module dmem_word_ram
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic [STRB_W-1:0] we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
    logic [WORD_W-1:0] rdata_q;

    // Read returns the pre-write contents; the responder only uses it for reads.
    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (we_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: request latch, latency timer,
// address check and held response in front of a byte-writable word RAM.
//
//   state   | meaning
//   IDLE    | ready for a request (req_ready=1)
//   WAIT    | request latched, counting down added latency
//   RESP    | response presented, held until rsp_ready
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int               AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0]      ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
    localparam logic [CNT_W-1:0] CNT_INIT   = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q;
    logic [31:0]         addr_q;
    logic [31:0]         wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic                err_q, err_d;
    logic                rd_q, rd_d;

    logic                accept;
    logic                enter_resp;
    logic                acc_we;
    logic [31:0]         acc_addr;
    logic [31:0]         acc_wdata;
    logic [STRB_W-1:0]   acc_wstrb;
    logic                acc_err;
    logic                ram_en;
    logic [STRB_W-1:0]   ram_we;
    logic [WORD_W-1:0]   ram_rdata;

    assign accept = req_valid && (state_q == ST_IDLE);

    // With zero latency the access happens on the accept edge, so it must
    // come straight from the request pins rather than the latch.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_wstrb = req_wstrb;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_wstrb = wstrb_q;
        end
    end

    assign acc_err    = (acc_addr[1:0] != 2'b00) || ({1'b0, acc_addr} >= ADDR_LIMIT);
    assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
    assign ram_en     = enter_resp && !reset;
    assign ram_we     = (acc_we && !acc_err) ? acc_wstrb : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        err_d = err_q;
        rd_d  = rd_q;
        if (enter_resp) begin
            err_d = acc_err;
            rd_d  = !acc_we && !acc_err;
        end else if ((state_q == ST_RESP) && rsp_ready) begin
            err_d = 1'b0;
            rd_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
            end
        end
    end

    dmem_word_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk     (clk),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (acc_addr[AW+1:2]),
        .wdata_i (acc_wdata),
        .rdata_o (ram_rdata)
    );

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && rd_q) ? ram_rdata : '0;

endmodule
